// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM responder.
// State encoding, bus width and byte-lane indices.
package sram_pkg;

    localparam int SRAM_DW = 16;
    localparam int LANE_LO = 0;
    localparam int LANE_HI = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_DRIVE,
        ST_WR_HOLD
    } state_e;

endpackage

// File: rtl/sram_byte_array.sv
// Two-lane halfword store: per-lane synchronous write, async read.
// Ports: clk_i, waddr_i, wdata_i, we_i[LANE_HI:LANE_LO], raddr_i, rdata_o.
module sram_byte_array
    import sram_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic               clk_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [SRAM_DW-1:0] wdata_i,
    input  logic [1:0]         we_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [SRAM_DW-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] mem_lo [DEPTH];
    logic [7:0] mem_hi [DEPTH];

    // No reset: contents survive a responder reset.
    always_ff @(posedge clk_i) begin
        if (we_i[LANE_LO]) begin
            mem_lo[waddr_i] <= wdata_i[7:0];
        end
        if (we_i[LANE_HI]) begin
            mem_hi[waddr_i] <= wdata_i[15:8];
        end
    end

    assign rdata_o = {mem_hi[raddr_i], mem_lo[raddr_i]};

endmodule

// File: rtl/sram_responder.sv
// Device end of the 16-bit async-SRAM bus: latency-delayed reads,
// per-lane writes, access counters and a sticky protocol-error flag.
// Ports: clk, rst (sync, active high), SRAM_DQ (tri-state), SRAM_ADDR,
//   SRAM_UB_N/LB_N/CE_N/OE_N/WE_N (active low), rd_cnt, wr_cnt, proto_err.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int READ_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    input  logic [ADDR_W-1:0]  SRAM_ADDR,
    input  logic               SRAM_UB_N,
    input  logic               SRAM_LB_N,
    input  logic               SRAM_CE_N,
    input  logic               SRAM_OE_N,
    input  logic               SRAM_WE_N,
    output logic [CNT_W-1:0]   rd_cnt,
    output logic [CNT_W-1:0]   wr_cnt,
    output logic               proto_err
);

    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LAT - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [SRAM_DW-1:0] wdata_q, wdata_d;
    logic [1:0]         lanes_q, lanes_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic               err_q, err_d;
    logic               commit;

    logic req_rd, req_wr, req_bad, addr_chg;
    logic [1:0] lanes_in;

    assign req_rd   = ~SRAM_CE_N & ~SRAM_OE_N & SRAM_WE_N;
    assign req_wr   = ~SRAM_CE_N & ~SRAM_WE_N & SRAM_OE_N;
    assign req_bad  = ~SRAM_CE_N & ~SRAM_OE_N & ~SRAM_WE_N;
    assign addr_chg = (SRAM_ADDR != addr_q);
    assign lanes_in = {~SRAM_UB_N, ~SRAM_LB_N};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        lat_d    = lat_q;
        wdata_d  = wdata_q;
        lanes_d  = lanes_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        err_d    = err_q;
        commit   = 1'b0;
        if (req_bad) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_rd) begin
                        state_d = ST_RD_WAIT;
                        addr_d  = SRAM_ADDR;
                        lat_d   = LAT_INIT;
                    end else if (req_wr) begin
                        state_d = ST_WR_HOLD;
                        addr_d  = SRAM_ADDR;
                        wdata_d = SRAM_DQ;
                        lanes_d = lanes_in;
                    end
                end
                ST_RD_WAIT: begin
                    if (!req_rd) begin
                        state_d = ST_IDLE;
                    end else if (addr_chg) begin
                        addr_d = SRAM_ADDR;
                        lat_d  = LAT_INIT;
                    end else if (lat_q == '0) begin
                        state_d  = ST_DRIVE;
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end else begin
                        lat_d = lat_q - 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (SRAM_OE_N || SRAM_CE_N) begin
                        state_d = ST_IDLE;
                    end else if (addr_chg) begin
                        state_d = ST_RD_WAIT;
                        addr_d  = SRAM_ADDR;
                        lat_d   = LAT_INIT;
                    end
                end
                ST_WR_HOLD: begin
                    if (req_wr) begin
                        if (addr_chg) begin
                            // Address moved under an open write.
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            wdata_d = SRAM_DQ;
                            lanes_d = lanes_in;
                        end
                    end else begin
                        // Request released: commit last capture.
                        commit   = 1'b1;
                        wr_cnt_d = wr_cnt_q + 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            lat_q    <= '0;
            wdata_q  <= '0;
            lanes_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            lat_q    <= lat_d;
            wdata_q  <= wdata_d;
            lanes_q  <= lanes_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            err_q    <= err_d;
        end
    end

    logic [1:0]         arr_we;
    logic [SRAM_DW-1:0] rdata;

    // Reset wins over a commit on the same edge.
    assign arr_we = (commit && !rst) ? lanes_q : 2'b00;

    sram_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .we_i    (arr_we),
        .raddr_i (addr_q),
        .rdata_o (rdata)
    );

    // Lanes follow the live enables; rst releases the bus at once.
    logic drv, oe_hi, oe_lo;

    assign drv   = (state_q == ST_DRIVE) && !rst;
    assign oe_hi = drv && !SRAM_UB_N;
    assign oe_lo = drv && !SRAM_LB_N;

    assign SRAM_DQ[15:8] = oe_hi ? rdata[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = oe_lo ? rdata[7:0]  : 8'hzz;

    assign rd_cnt    = rd_cnt_q;
    assign wr_cnt    = wr_cnt_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder with a read-data scoreboard.
// A second small instance covers READ_LAT=1 and counter wrap.
module tb_sram_responder;

    localparam int RL = 2;

    logic        clk;
    logic        rst;
    logic [17:0] addr;
    logic        ub_n, lb_n, ce_n, oe_n, we_n;
    wire  [15:0] dq;
    logic [15:0] tb_dq;
    logic        tb_en_hi, tb_en_lo;
    logic [15:0] rd_cnt, wr_cnt;
    logic        proto_err;

    logic [3:0]  f_addr;
    logic        f_lane_n, f_ce_n, f_oe_n, f_we_n;
    wire  [15:0] f_dq;
    logic [15:0] f_tb_dq;
    logic        f_en;
    logic [3:0]  f_rd_cnt, f_wr_cnt;
    logic        f_err;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    assign dq[15:8] = tb_en_hi ? tb_dq[15:8] : 8'hzz;
    assign dq[7:0]  = tb_en_lo ? tb_dq[7:0]  : 8'hzz;
    assign f_dq     = f_en ? f_tb_dq : 16'hzzzz;

    sram_responder #(
        .ADDR_W   (18),
        .READ_LAT (RL),
        .CNT_W    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SRAM_DQ   (dq),
        .SRAM_ADDR (addr),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n),
        .SRAM_WE_N (we_n),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt),
        .proto_err (proto_err)
    );

    sram_responder #(
        .ADDR_W   (4),
        .READ_LAT (1),
        .CNT_W    (4)
    ) dut_fast (
        .clk       (clk),
        .rst       (rst),
        .SRAM_DQ   (f_dq),
        .SRAM_ADDR (f_addr),
        .SRAM_UB_N (f_lane_n),
        .SRAM_LB_N (f_lane_n),
        .SRAM_CE_N (f_ce_n),
        .SRAM_OE_N (f_oe_n),
        .SRAM_WE_N (f_we_n),
        .rd_cnt    (f_rd_cnt),
        .wr_cnt    (f_wr_cnt),
        .proto_err (f_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
        ub_n = 1'b1; lb_n = 1'b1;
        tb_en_hi = 1'b0; tb_en_lo = 1'b0;
    endtask

    // Bus reads back exactly the bench's zero drive only if DUT is off.
    task automatic chk_released(input string tag);
        tb_dq = 16'h0000; tb_en_hi = 1'b1; tb_en_lo = 1'b1;
        #1;
        chk(tag, dq, 16'h0000);
        tb_en_hi = 1'b0; tb_en_lo = 1'b0;
    endtask

    task automatic write(input logic [17:0] a, input logic [15:0] d,
                         input logic ub, input logic lb, input int hold);
        @(negedge clk);
        addr = a; tb_dq = d; tb_en_hi = 1'b1; tb_en_lo = 1'b1;
        ub_n = ub; lb_n = lb; oe_n = 1'b1; ce_n = 1'b0; we_n = 1'b0;
        repeat (hold) @(negedge clk);
        we_n = 1'b1;
        @(negedge clk);
        idle();
    endtask

    // Leaves the DUT in DRIVE; caller ends with read_end().
    task automatic read(input string tag, input logic [17:0] a,
                        input logic [15:0] exp);
        @(negedge clk);
        addr = a; ub_n = 1'b0; lb_n = 1'b0;
        we_n = 1'b1; oe_n = 1'b0; ce_n = 1'b0;
        exp_q.push_back(exp);
        repeat (RL) @(negedge clk);
        chk_released({tag, "_early"});
        @(negedge clk);
        chk(tag, dq, exp_q.pop_front());
    endtask

    task automatic read_end();
        idle();
        @(negedge clk);
    endtask

    task automatic f_idle();
        f_ce_n = 1'b1; f_oe_n = 1'b1; f_we_n = 1'b1;
        f_lane_n = 1'b1; f_en = 1'b0;
    endtask

    task automatic f_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        f_addr = a; f_tb_dq = d; f_en = 1'b1; f_lane_n = 1'b0;
        f_ce_n = 1'b0; f_oe_n = 1'b1; f_we_n = 1'b0;
        @(negedge clk);
        f_we_n = 1'b1;
        @(negedge clk);
        f_idle();
    endtask

    initial begin
        rst = 1'b1; addr = '0; tb_dq = '0; idle();
        f_addr = '0; f_tb_dq = '0; f_idle();
        repeat (2) @(negedge clk);
        chk("rst_rd_cnt", rd_cnt, 0);
        chk("rst_wr_cnt", wr_cnt, 0);
        chk("rst_err", proto_err, 0);
        chk_released("rst_dq");
        rst = 1'b0;

        write(18'h00010, 16'hBEEF, 1'b0, 1'b0, 3);
        chk("wr_cnt_1", wr_cnt, 1);
        read("rd_beef", 18'h00010, 16'hBEEF);
        read_end();
        chk("rd_cnt_1", rd_cnt, 1);

        write(18'h00010, 16'h0012, 1'b1, 1'b0, 2);
        chk("wr_cnt_2", wr_cnt, 2);
        read("rd_be12", 18'h00010, 16'hBE12);
        lb_n = 1'b1; tb_dq = 16'h0000; tb_en_lo = 1'b1;
        #1;
        chk("ub_only", dq, 16'hBE00);
        tb_en_lo = 1'b0;
        read_end();
        chk("rd_cnt_2", rd_cnt, 2);

        @(negedge clk);
        addr = 18'h3FFFF; ub_n = 1'b0; lb_n = 1'b0;
        we_n = 1'b1; oe_n = 1'b0; ce_n = 1'b0;
        @(negedge clk);
        chk_released("abort_dq0");
        oe_n = 1'b1; ce_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_released("abort_dq");
        end
        chk("abort_rd_cnt", rd_cnt, 2);

        @(negedge clk);
        addr = 18'h00010; tb_dq = 16'hFFFF;
        tb_en_hi = 1'b1; tb_en_lo = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
        ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b0;
        @(negedge clk);
        idle();
        chk("bad_err", proto_err, 1);
        chk_released("bad_dq");
        @(negedge clk);
        chk("bad_wr_cnt", wr_cnt, 2);
        read("bad_nochg", 18'h00010, 16'hBE12);
        read_end();
        chk("err_sticky", proto_err, 1);

        write(18'h00020, 16'hCAFE, 1'b0, 1'b0, 1);
        write(18'h00030, 16'h1111, 1'b0, 1'b0, 1);
        write(18'h00031, 16'h2222, 1'b0, 1'b0, 1);
        chk("wr_cnt_5", wr_cnt, 5);

        @(negedge clk);
        addr = 18'h00020; tb_dq = 16'h1234;
        tb_en_hi = 1'b1; tb_en_lo = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
        ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("wrrst_rd_cnt", rd_cnt, 0);
        chk("wrrst_wr_cnt", wr_cnt, 0);
        chk("wrrst_err", proto_err, 0);
        chk("wrrst_dq", dq, 16'h1234);
        idle();
        rst = 1'b0;
        @(negedge clk);
        read("wrrst_old", 18'h00020, 16'hCAFE);
        read_end();
        chk("wrrst_rd_cnt1", rd_cnt, 1);

        @(negedge clk);
        addr = 18'h00030; tb_dq = 16'h5555;
        tb_en_hi = 1'b1; tb_en_lo = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
        ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
        @(negedge clk);
        addr = 18'h00031;
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("achg_err", proto_err, 1);
        chk("achg_wr_cnt", wr_cnt, 0);
        read("achg_30", 18'h00030, 16'h1111);
        read_end();
        read("achg_31", 18'h00031, 16'h2222);
        read_end();

        f_write(4'h3, 16'hA5A5);
        f_write(4'h4, 16'h5A5A);
        chk("f_wr_cnt", f_wr_cnt, 2);
        @(negedge clk);
        f_addr = 4'h3; f_lane_n = 1'b0;
        f_ce_n = 1'b0; f_oe_n = 1'b0; f_we_n = 1'b1;
        exp_q.push_back(16'hA5A5);
        repeat (2) @(negedge clk);
        chk("f_lat1", f_dq, exp_q.pop_front());
        for (int i = 1; i < 16; i++) begin
            f_addr = (i % 2 == 1) ? 4'h4 : 4'h3;
            exp_q.push_back((i % 2 == 1) ? 16'h5A5A : 16'hA5A5);
            repeat (2) @(negedge clk);
            chk("f_b2b", f_dq, exp_q.pop_front());
            if (i == 14) begin
                chk("f_rd_cnt15", f_rd_cnt, 15);
            end
        end
        chk("f_wrap", f_rd_cnt, 0);
        f_idle();
        @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
